// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
// Font codes are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned C_BIN_W      = 14;
    localparam int unsigned C_BCD_W      = 16;
    localparam int unsigned C_DIGITS     = 4;
    localparam int unsigned C_MAX_VAL    = 9999;
    localparam int unsigned C_CONV_STEPS = 14;
    localparam int unsigned C_STEP_W     = 4;

    localparam logic [7:0] C_BLANK = 8'hFF;

    // Entry n holds the glyph for decimal digit n
    localparam logic [9:0][7:0] C_FONT = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] font_of(input logic [3:0] nib);
        logic [7:0] f;
        f = C_BLANK;
        if (nib <= 4'd9) begin
            f = C_FONT[nib];
        end
        return f;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_bin2bcd_iter.sv
// Iterative double-dabble: one adjust-and-shift step per clock, 14 steps per value.
// last_c flags the cycle whose edge performs the final step; done pulses the cycle after.
module bin2bcd_iter
    import fnd_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  start,
    input  logic [C_BIN_W-1:0]    bin,
    output logic                  busy,
    output logic                  last_c,
    output logic                  done,
    output logic [C_BCD_W-1:0]    result
);

    logic [C_BIN_W-1:0]  bin_q;
    logic [C_STEP_W-1:0] step_q;
    logic [C_BCD_W-1:0]  adj_c;

    assign last_c = busy && (step_q == C_STEP_W'(C_CONV_STEPS - 1));

    // Add 3 to every nibble >= 5 so the following shift carries correctly
    always_comb begin
        adj_c = result;
        for (int k = 0; k < int'(C_DIGITS); k++) begin
            if (result[4*k +: 4] >= 4'd5) begin
                adj_c[4*k +: 4] = result[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bin_q  <= '0;
            result <= '0;
            step_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start && !busy) begin
            bin_q  <= bin;
            result <= '0;
            step_q <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            result <= {adj_c[C_BCD_W-2:0], bin_q[C_BIN_W-1]};
            bin_q  <= {bin_q[C_BIN_W-2:0], 1'b0};
            step_q <= step_q + C_STEP_W'(1);
            if (last_c) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Accepts a saturated binary value, converts it to BCD and scans the four
// digits onto active-low common/segment lines at a programmable rate.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned P_SCAN_DIV = 100000,
    parameter int unsigned P_WIDTH    = 14
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [P_WIDTH-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_blank_lz,
    input  logic [3:0]         i_dp,
    output logic [3:0]         o_fndCom,
    output logic [7:0]         o_fndFont,
    output logic [15:0]        o_bcd
);

    localparam int unsigned W_PRESC = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;

    state_t               state_q;
    state_t               state_d;
    logic                 accept_c;
    logic                 start_c;
    logic                 load_bcd_c;
    logic                 ready_d;
    logic [C_BIN_W-1:0]   sat_c;
    logic                 eng_busy;
    logic                 eng_last_c;
    logic                 eng_done;
    logic [C_BCD_W-1:0]   eng_result;

    logic [W_PRESC-1:0]   presc_q;
    logic                 tick_c;
    logic [1:0]           idx_q;
    logic [3:0]           nib_c;
    logic                 upper_zero_c;
    logic [7:0]           font_c;

    assign accept_c = i_valid && o_ready;
    assign sat_c    = (i_data > P_WIDTH'(C_MAX_VAL)) ? C_BIN_W'(C_MAX_VAL) : C_BIN_W'(i_data);

    bin2bcd_iter u_bin2bcd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .start     (start_c),
        .bin       (sat_c),
        .busy      (eng_busy),
        .last_c    (eng_last_c),
        .done      (eng_done),
        .result    (eng_result)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept_c)              state_d = CONV;
            CONV: if (eng_busy && eng_last_c) state_d = DONE;
            DONE: if (eng_done)              state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        start_c    = 1'b0;
        load_bcd_c = 1'b0;
        ready_d    = (state_d == IDLE);
        unique case (state_q)
            IDLE:    start_c    = accept_c;
            DONE:    load_bcd_c = eng_done;
            default: ;
        endcase
    end

    // Display register updates atomically once the engine has finished
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ready <= 1'b1;
            o_bcd   <= '0;
        end else begin
            o_ready <= ready_d;
            if (load_bcd_c) begin
                o_bcd <= eng_result;
            end
        end
    end

    assign tick_c = (presc_q == W_PRESC'(P_SCAN_DIV - 1));

    // Free-running scan; never gated by the conversion FSM
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (tick_c) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + W_PRESC'(1);
        end
    end

    // A digit is blanked when it and every more significant digit are zero
    always_comb begin
        nib_c        = o_bcd[{idx_q, 2'b00} +: 4];
        upper_zero_c = 1'b1;
        for (int k = 0; k < int'(C_DIGITS); k++) begin
            if ((2'(k) >= idx_q) && (o_bcd[4*k +: 4] != 4'd0)) begin
                upper_zero_c = 1'b0;
            end
        end
        font_c    = font_of(nib_c);
        font_c[7] = ~i_dp[idx_q];
        if (i_blank_lz && (idx_q != 2'd0) && upper_zero_c) begin
            font_c = C_BLANK;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fndCom  <= 4'b1110;
            o_fndFont <= 8'hC0;
        end else begin
            o_fndCom  <= ~(4'b0001 << idx_q);
            o_fndFont <= font_c;
        end
    end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Sequences a 4-digit 7-segment (FND) display from a 14-bit binary value.
- Accepts a value through a valid/ready handshake and saturates it to 9999.
- Converts the value to 4 BCD digits with an iterative double-dabble engine, then time-multiplexes the digits onto common/segment lines at a programmable scan rate.
- Sits between the PWM/status logic that produces the value and the board FND pins.

Parameters:
- P_SCAN_DIV, 100000: clock cycles per digit slot. Must be at least 2. Use 4 in simulation.
- P_WIDTH, 14: binary input width. Fixed at 14; values up to 16383.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  14  binary value to display.
- i_valid  in  1  i_data is valid this cycle.
- o_ready  out  1  controller can accept a value.
- i_blank_lz  in  1  enables leading-zero blanking.
- i_dp  in  4  decimal-point enable per digit. Bit 0 is the ones digit.
- o_fndCom  out  4  digit commons, active-low one-hot.
- o_fndFont  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_bcd  out  16  displayed BCD value {thousands,hundreds,tens,ones}.

Behaviour:
- Reset state (asynchronous, while i_reset_n=0):
  - FSM=IDLE, o_ready=1, display register o_bcd=16'h0000.
  - Digit index=0, prescaler=0.
  - o_fndCom=4'b1110, o_fndFont=8'hC0.
- FSM states IDLE, CONV, DONE:
  - IDLE: o_ready=1. On an edge with i_valid&&o_ready (accept edge E0):
    - capture min(i_data,9999) into the shift register;
    - clear the BCD accumulator and the 4-bit step counter;
    - go to CONV.
  - CONV: each edge, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1 and increment the step counter. After the 14th step (edge E14), go to DONE.
  - DONE: at edge E15, copy the accumulator into o_bcd atomically and go to IDLE.
  - o_ready is low for exactly the 15 cycles following E0.
- Latency: o_bcd shows the new value 15 cycles after the accept edge. Segment outputs reflect it one cycle after that.
- i_valid while o_ready=0 is ignored. It is not queued and has no effect on the conversion in progress.
- Scan timing:
  - The prescaler counts 0..P_SCAN_DIV-1 and wraps.
  - A tick occurs when it equals P_SCAN_DIV-1.
  - On a tick, the digit index advances 0→1→2→3→0.
  - Scanning runs continuously and independently of the FSM. Conversion never stalls the scan.
- Output generation (registered, 1-cycle latency from index/o_bcd):
  - o_fndCom = ~(4'b0001 << idx).
  - o_fndFont = font(nibble[idx]) with bit7 = ~i_dp[idx].
- Font table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any non-BCD nibble shows FF (unreachable; defensive).
- Leading-zero blanking: when i_blank_lz=1 and idx>0 and every nibble from idx up to 3 is 0, o_fndFont=8'hFF (segments and dp off).
  - The ones digit is never blanked.
  - Internal zeros (e.g. 1005) are shown.
- Simultaneous events:
  - A tick on the same edge as the o_bcd update: the next registered font uses the new o_bcd.
  - An accept and a tick on the same edge are independent.
- Reset asserted mid-conversion: aborts immediately and returns to the reset state. The partial result is discarded and o_bcd=0.

Decomposition:
- Package fnd_pkg holds:
  - FSM state enum {IDLE,CONV,DONE};
  - C_MAX_VAL=9999 and C_CONV_STEPS=14;
  - the font constant array (10 entries);
  - C_BLANK=8'hFF.
- One sub-module, bin2bcd_iter: the iterative double-dabble engine with start/busy/done and a 16-bit result. fnd_scan_controller owns the handshake, display register, prescaler, index and font logic.

Test Plan (P_SCAN_DIV=4):
- Reset: release i_reset_n → o_ready=1, o_bcd=0000, o_fndCom=1110, o_fndFont=C0. Over 16 cycles, o_fndCom cycles 1110→1101→1011→0111 with all fonts C0.
- Load 1234: i_valid for 1 cycle → o_ready low for 15 cycles, then o_bcd=16'h1234 15 cycles after accept. Fonts by digit are 0:99, 1:B0, 2:A4, 3:F9.
- Saturation: i_data=16383 → o_bcd=16'h9999, all fonts 90. i_data=10000 → also 9999.
- Blanking: i_blank_lz=1.
  - Value 7 → digit0 F8, digits 1-3 FF.
  - Value 0 → digit0 C0, others FF.
  - Value 1005 → C0 shown on digits 1-2.
  - With i_blank_lz=0 and value 7, digits 1-3 show C0.
- Busy/reset:
  - A second i_valid with value 42 during CONV is ignored; o_bcd = first value.
  - Pulse i_reset_n low during CONV → o_bcd=0000, o_ready=1 after release, and the next accept converts correctly.
- Decimal point: value 2222 with i_dp=0100 → digit2 font 24, other digits A4.
